// File: rtl/alarm_snooze_ctrl.sv
// alarm_snooze_ctrl: snooze/stop/auto-off sequencer that owns the alarm write path of ALARM_CLOCK.
// Optional ALARM_SNOOZE_AUTO_OFF_EN builds the ring-seconds counter and timeout exit.
module alarm_snooze_ctrl #(
    parameter int unsigned SNOOZE_MIN     = 9,
    parameter int unsigned MAX_SNOOZE     = 3,
    parameter int unsigned RING_TIMEOUT_S = 60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic [3:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic       alarm_ringing,
    input  logic       snooze_req,
    input  logic       stop_req,
    input  logic       user_set_alarm,
    input  logic [3:0] user_alarm_hours,
    input  logic [5:0] user_alarm_minutes,
    output logic       set_alarm,
    output logic [3:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic       buzzer,
    output logic       snoozing,
    output logic [2:0] snooze_count
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RING     = 3'd1;
    localparam logic [2:0] SNZ_LOAD = 3'd2;
    localparam logic [2:0] SNZ_WAIT = 3'd3;
    localparam logic [2:0] RESTORE  = 3'd4;
    localparam logic [2:0] MUTED    = 3'd5;

    logic [2:0] r_state;
    logic       r_ring_q;
    logic [3:0] r_base_h;
    logic [5:0] r_base_m;
    logic       w_ring_rise;
    logic       w_timeout;
    logic       w_snz_ok;
    logic       w_carry;
    logic [6:0] w_sum;
    logic [3:0] w_snz_h;
    logic [5:0] w_snz_m;
    logic [3:0] w_rst_h;
    logic [5:0] w_rst_m;

    assign w_ring_rise = alarm_ringing & ~r_ring_q;
    assign w_snz_ok    = snooze_count < MAX_SNOOZE[2:0];
    assign w_sum       = {1'b0, cur_minutes} + SNOOZE_MIN[6:0];
    assign w_carry     = w_sum >= 7'd60;
    assign w_snz_m     = w_carry ? 6'(w_sum - 7'd60) : w_sum[5:0];
    assign w_snz_h     = !w_carry ? cur_hours : (cur_hours == 4'd11 ? 4'd0 : cur_hours + 4'd1);
    // A base written in the same cycle as the restoring event must still win.
    assign w_rst_h     = user_set_alarm ? user_alarm_hours : r_base_h;
    assign w_rst_m     = user_set_alarm ? user_alarm_minutes : r_base_m;

`ifdef ALARM_SNOOZE_AUTO_OFF_EN
    logic [7:0] r_ring_sec;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_ring_sec <= 8'd0;
        else
            r_ring_sec <= (r_state == RING) ? r_ring_sec + {7'd0, sec_tick} : 8'd0;
    end
    assign w_timeout = r_ring_sec == RING_TIMEOUT_S[7:0];
`else
    logic w_unused;
    assign w_unused  = sec_tick ^ (RING_TIMEOUT_S == 0);
    assign w_timeout = 1'b0;
`endif

    // Outputs are registered alongside the state so they appear in the target state's first cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ring_q      <= 1'b0;
            r_base_h      <= 4'd0;
            r_base_m      <= 6'd0;
            set_alarm     <= 1'b0;
            alarm_hours   <= 4'd0;
            alarm_minutes <= 6'd0;
            buzzer        <= 1'b0;
            snoozing      <= 1'b0;
            snooze_count  <= 3'd0;
        end else begin
            r_ring_q  <= alarm_ringing;
            set_alarm <= 1'b0;
            if (user_set_alarm) begin
                r_base_h <= user_alarm_hours;
                r_base_m <= user_alarm_minutes;
            end
            case (r_state)
                IDLE: begin
                    if (w_ring_rise) begin
                        r_state <= RING;
                        buzzer  <= 1'b1;
                    end else if (user_set_alarm) begin
                        set_alarm     <= 1'b1;
                        alarm_hours   <= user_alarm_hours;
                        alarm_minutes <= user_alarm_minutes;
                    end
                end
                RING: begin
                    if (stop_req || w_timeout) begin
                        r_state       <= RESTORE;
                        buzzer        <= 1'b0;
                        set_alarm     <= 1'b1;
                        alarm_hours   <= w_rst_h;
                        alarm_minutes <= w_rst_m;
                        snooze_count  <= 3'd0;
                    end else if (snooze_req && w_snz_ok) begin
                        r_state       <= SNZ_LOAD;
                        buzzer        <= 1'b0;
                        set_alarm     <= 1'b1;
                        alarm_hours   <= w_snz_h;
                        alarm_minutes <= w_snz_m;
                        snooze_count  <= snooze_count + 3'd1;
                    end
                end
                SNZ_LOAD: begin
                    r_state  <= SNZ_WAIT;
                    snoozing <= 1'b1;
                end
                SNZ_WAIT: begin
                    if (w_ring_rise) begin
                        r_state  <= RING;
                        buzzer   <= 1'b1;
                        snoozing <= 1'b0;
                    end else if (stop_req) begin
                        r_state       <= RESTORE;
                        snoozing      <= 1'b0;
                        set_alarm     <= 1'b1;
                        alarm_hours   <= w_rst_h;
                        alarm_minutes <= w_rst_m;
                        snooze_count  <= 3'd0;
                    end
                end
                RESTORE: r_state <= MUTED;
                MUTED: if (!alarm_ringing) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// tb_alarm_snooze_ctrl: directed bench for alarm_snooze_ctrl; follows ALARM_SNOOZE_AUTO_OFF_EN if defined.
module tb_alarm_snooze_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sec_tick = 1'b0;
    logic [3:0] cur_hours = 4'd0;
    logic [5:0] cur_minutes = 6'd0;
    logic       alarm_ringing = 1'b0;
    logic       snooze_req = 1'b0;
    logic       stop_req = 1'b0;
    logic       user_set_alarm = 1'b0;
    logic [3:0] user_alarm_hours = 4'd0;
    logic [5:0] user_alarm_minutes = 6'd0;
    logic       set_alarm;
    logic [3:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       buzzer;
    logic       snoozing;
    logic [2:0] snooze_count;
    int errs = 0;
    int checks = 0;

    alarm_snooze_ctrl dut (
        .clock(clock), .reset(reset), .sec_tick(sec_tick),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes),
        .alarm_ringing(alarm_ringing), .snooze_req(snooze_req), .stop_req(stop_req),
        .user_set_alarm(user_set_alarm), .user_alarm_hours(user_alarm_hours),
        .user_alarm_minutes(user_alarm_minutes), .set_alarm(set_alarm),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .buzzer(buzzer),
        .snoozing(snoozing), .snooze_count(snooze_count)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snz(input logic [3:0] h, input logic [5:0] m);
        cur_hours = h;
        cur_minutes = m;
        snooze_req = 1'b1;
        alarm_ringing = 1'b0;
        tick;
        snooze_req = 1'b0;
    endtask

    initial begin
        tick;
        tick;
        chk("rst_set", set_alarm, 0);
        chk("rst_hm", {alarm_hours, alarm_minutes}, 0);
        chk("rst_flags", {buzzer, snoozing, snooze_count}, 0);
        reset = 1'b0;
        tick;
        // base set in IDLE
        user_set_alarm = 1'b1; user_alarm_hours = 4'd7; user_alarm_minutes = 6'd30;
        tick;
        user_set_alarm = 1'b0;
        chk("base_pulse", set_alarm, 1);
        chk("base_hm", {alarm_hours, alarm_minutes}, {4'd7, 6'd30});
        tick;
        chk("base_pulse_end", set_alarm, 0);
        chk("base_hold", {alarm_hours, alarm_minutes}, {4'd7, 6'd30});
        // ring then stop
        alarm_ringing = 1'b1;
        tick;
        chk("ring_buzz", buzzer, 1);
        stop_req = 1'b1;
        tick;
        stop_req = 1'b0;
        chk("stop_pulse", {set_alarm, buzzer}, 2'b10);
        chk("stop_hm", {alarm_hours, alarm_minutes}, {4'd7, 6'd30});
        tick;
        tick;
        chk("muted", {set_alarm, buzzer}, 0);
        alarm_ringing = 1'b0;
        tick;
        // snooze with hour wrap
        cur_hours = 4'd11; cur_minutes = 6'd55;
        alarm_ringing = 1'b1;
        tick;
        chk("ring2_buzz", buzzer, 1);
        snz(4'd11, 6'd55);
        chk("snz1_pulse", {set_alarm, buzzer}, 2'b10);
        chk("snz1_hm", {alarm_hours, alarm_minutes}, {4'd0, 6'd4});
        chk("snz1_cnt", snooze_count, 1);
        tick;
        chk("snz1_wait", {snoozing, set_alarm, buzzer}, 3'b100);
        alarm_ringing = 1'b1;
        tick;
        chk("rering", {buzzer, snoozing}, 2'b10);
        // snooze limit
        snz(4'd3, 6'd20);
        chk("snz2_hm", {alarm_hours, alarm_minutes}, {4'd3, 6'd29});
        chk("snz2_cnt", snooze_count, 2);
        tick;
        alarm_ringing = 1'b1;
        tick;
        snz(4'd3, 6'd51);
        chk("snz3_hm", {alarm_hours, alarm_minutes}, {4'd4, 6'd0});
        chk("snz3_cnt", snooze_count, 3);
        tick;
        alarm_ringing = 1'b1;
        tick;
        snooze_req = 1'b1;
        tick;
        snooze_req = 1'b0;
        chk("snz4_rej", {buzzer, set_alarm, snooze_count}, {1'b1, 1'b0, 3'd3});
        // simultaneous snooze and stop
        snooze_req = 1'b1; stop_req = 1'b1;
        tick;
        snooze_req = 1'b0; stop_req = 1'b0;
        chk("both_pulse", {set_alarm, buzzer, snoozing, snooze_count}, {1'b1, 1'b0, 1'b0, 3'd0});
        chk("both_hm", {alarm_hours, alarm_minutes}, {4'd7, 6'd30});
        alarm_ringing = 1'b0;
        tick;
        tick;
        // auto-off
        alarm_ringing = 1'b1;
        tick;
        for (int i = 0; i < 60; i++) begin
            sec_tick = 1'b1;
            tick;
            sec_tick = 1'b0;
        end
        chk("to_60_buzz", {buzzer, set_alarm}, 2'b10);
        tick;
`ifdef ALARM_SNOOZE_AUTO_OFF_EN
        chk("to_restore", {set_alarm, buzzer, snooze_count}, {1'b1, 1'b0, 3'd0});
        chk("to_hm", {alarm_hours, alarm_minutes}, {4'd7, 6'd30});
`else
        chk("to_none", {buzzer, set_alarm}, 2'b10);
        for (int i = 0; i < 40; i++) begin
            sec_tick = 1'b1;
            tick;
            sec_tick = 1'b0;
        end
        chk("to_100_buzz", buzzer, 1);
        stop_req = 1'b1;
        tick;
        stop_req = 1'b0;
`endif
        alarm_ringing = 1'b0;
        tick;
        tick;
        // deferred base update
        alarm_ringing = 1'b1;
        tick;
        snz(4'd5, 6'd0);
        chk("snz5_hm", {alarm_hours, alarm_minutes}, {4'd5, 6'd9});
        tick;
        user_set_alarm = 1'b1; user_alarm_hours = 4'd6; user_alarm_minutes = 6'd0;
        tick;
        user_set_alarm = 1'b0;
        chk("defer_nopulse", {set_alarm, alarm_hours}, {1'b0, 4'd5});
        stop_req = 1'b1;
        tick;
        stop_req = 1'b0;
        chk("defer_pulse", {set_alarm, snoozing}, 2'b10);
        chk("defer_hm", {alarm_hours, alarm_minutes}, {4'd6, 6'd0});
        tick;
        tick;
        // reset mid-ring
        alarm_ringing = 1'b1;
        tick;
        snz(4'd2, 6'd10);
        tick;
        alarm_ringing = 1'b1;
        tick;
        chk("pre_rst", {buzzer, snooze_count}, {1'b1, 3'd1});
        reset = 1'b1;
        #1;
        chk("mid_rst", {set_alarm, buzzer, snoozing, snooze_count}, 0);
        chk("mid_rst_hm", {alarm_hours, alarm_minutes}, 0);
        reset = 1'b0;
        alarm_ringing = 1'b0;
        user_set_alarm = 1'b1; user_alarm_hours = 4'd8; user_alarm_minutes = 6'd15;
        tick;
        user_set_alarm = 1'b0;
        chk("post_rst_idle", {set_alarm, alarm_hours, alarm_minutes}, {1'b1, 4'd8, 6'd15});
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/alarm_snooze_ctrl.md
# alarm_snooze_ctrl

Controller that sits beside `ALARM_CLOCK` and sequences its alarm registers. It takes the user's base alarm setting and the core's `alarm_ringing` level, drives the buzzer, and reprograms the core through `set_alarm`, `alarm_hours` and `alarm_minutes` to implement snooze, stop and auto-off. It owns the only write path into the core's alarm registers; the core's time path (`set_time`) is untouched.

## Interface
Parameters:
- `SNOOZE_MIN`, default 9: minutes added to the current time per snooze, range 1..59.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm event, range 1..7.
- `RING_TIMEOUT_S`, default 60: seconds of continuous ringing before auto-off, range 1..255.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sec_tick`  in  1  one-cycle strobe per second.
- `cur_hours`  in  4  core current hours, 0..11.
- `cur_minutes`  in  6  core current minutes, 0..59.
- `alarm_ringing`  in  1  core level: current time equals the programmed alarm.
- `snooze_req`  in  1  one-cycle debounced snooze press.
- `stop_req`  in  1  one-cycle debounced stop press.
- `user_set_alarm`  in  1  one-cycle strobe that loads the base alarm.
- `user_alarm_hours`  in  4  base alarm hours.
- `user_alarm_minutes`  in  6  base alarm minutes.
- `set_alarm`  out  1  one-cycle load strobe to the core.
- `alarm_hours`  out  4  alarm hours value to the core.
- `alarm_minutes`  out  6  alarm minutes value to the core.
- `buzzer`  out  1  high while ringing.
- `snoozing`  out  1  high while waiting for a snooze to expire.
- `snooze_count`  out  3  snoozes used in the current event.

## Operation
- States: IDLE, RING, SNZ_LOAD, SNZ_WAIT, RESTORE, MUTED.
- Edge detect: `ring_rise = alarm_ringing & ~ring_q`, where `ring_q` is `alarm_ringing` registered.
- `user_set_alarm`: latches `base_h`/`base_m` in every state.
  - In IDLE, it also issues a `set_alarm` pulse carrying the base values.
  - In any other state, the new base is applied at RESTORE.
- IDLE:
  - `ring_rise` → RING, and the seconds counter clears.
  - If `ring_rise` and `user_set_alarm` occur together, RING wins and the base is latched without a pulse.
- RING: `buzzer`=1; `sec_tick` increments `ring_sec`. Events in priority order:
  - `stop_req` → RESTORE.
  - `ring_sec == RING_TIMEOUT_S` → RESTORE.
  - `snooze_req` with `snooze_count < MAX_SNOOZE` → SNZ_LOAD.
  - `snooze_req` with `snooze_count == MAX_SNOOZE` is ignored.
- SNZ_LOAD (one cycle):
  - Target minutes = `cur_minutes + SNOOZE_MIN`; if the sum ≥ 60, subtract 60 and carry one into hours.
  - Hours wrap 11 → 0.
  - Pulse `set_alarm` with the target and increment `snooze_count`. Next state SNZ_WAIT.
- SNZ_WAIT: `snoozing`=1, `buzzer`=0.
  - `ring_rise` → RING, and `ring_sec` clears.
  - `stop_req` → RESTORE.
- RESTORE (one cycle): pulse `set_alarm` with `base_h`/`base_m`, clear `snooze_count`, then go to MUTED.
- MUTED: `buzzer`=0. Stay until `alarm_ringing`==0, then go to IDLE. This blocks a retrigger within the same minute.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, `base_h`/`base_m` 0, `ring_q` 0, `ring_sec` 0, state IDLE.
- `buzzer` rises one cycle after the cycle in which `ring_rise` is sampled.
- `set_alarm` is high for exactly one cycle, one cycle after the triggering event (snooze, stop, timeout, or IDLE `user_set_alarm`).
- `alarm_hours`/`alarm_minutes` are valid in the same cycle as `set_alarm` and hold afterwards.
- `buzzer` falls in the same cycle that `set_alarm` rises for snooze, stop or timeout.
- Reset asserted mid-operation returns the block to IDLE immediately. It emits no `set_alarm`; the core keeps its last programmed value.

## Configuration
- `ALARM_SNOOZE_AUTO_OFF_EN`:
  - Defined: `ring_sec` and the RING_TIMEOUT_S exit are compiled in.
  - Undefined: no counter is built, and RING exits only on `stop_req` or an accepted `snooze_req`.

## Test plan
- Base set and ring then stop:
  - `user_set_alarm` with 7:30 in IDLE → `set_alarm` pulse carrying 7:30.
  - Raise `alarm_ringing` → `buzzer`=1 next cycle.
  - `stop_req` → RESTORE pulse carrying 7:30, then MUTED until `alarm_ringing` falls.
- Snooze with hour wrap:
  - Ringing at 11:55, `snooze_req` → `set_alarm` with 0:04, `snooze_count`=1, `snoozing`=1, `buzzer`=0.
  - Re-raise `alarm_ringing` → RING.
- Snooze limit:
  - Accept 3 snoozes; on the fourth `snooze_req`, `buzzer` stays 1, no `set_alarm` pulse, `snooze_count`=3.
- Auto-off (macro defined):
  - Ring for 60 `sec_tick`s → RESTORE with the base value, `buzzer`=0, `snooze_count`=0.
  - Without the macro, `buzzer` is still 1 after 100 ticks.
- Simultaneous and deferred events:
  - `snooze_req` and `stop_req` in the same cycle in RING → stop path.
  - `user_set_alarm` 6:00 during SNZ_WAIT, then stop → RESTORE emits 6:00.
- Reset mid-ring:
  - Assert `reset` while in RING → `buzzer`, `snoozing`, `snooze_count` and `set_alarm` all read 0 immediately, and the state is IDLE.
